// File: rtl/pe_mode_scheduler.sv
// rtl/pe_mode_scheduler.sv - issue scheduler for the multi-precision FP processing element
//
// Accepts product-group requests, drives the registered precision mode into
// the PE datapath, drains the pipeline before any mode change, tracks
// downstream result-buffer credits and tags each result with mode/last.
//
// Optional feature macro: PE_SCHED_PERF_EN (adds perf_issue / perf_stall).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     request handshake; in_mode (00 FP16, 01 FP32,
//                         10 FP64, 11 reserved), in_last ends a group
//   pe_issue, pe_mode,    operand-load strobe, registered datapath mode,
//   pe_acc_clr            accumulator clear qualifying pe_issue
//   res_valid/last/mode   result strobe and its tags, PIPE_LAT after issue
//   res_pop               one result-buffer entry freed (credit return)
//   credits               free result-buffer entries
//   busy                  not in RUN, or operations in flight
//   err_mode              sticky: reserved mode seen or mode change mid-group
//   perf_issue/perf_stall saturating counters (PE_SCHED_PERF_EN only)

module pe_mode_scheduler #(
  parameter  int PIPE_LAT = 4,
  parameter  int CREDITS  = 8,
  localparam int CW       = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_mode,
  input  logic          in_last,
  output logic          pe_issue,
  output logic [1:0]    pe_mode,
  output logic          pe_acc_clr,
  output logic          res_valid,
  output logic          res_last,
  output logic [1:0]    res_mode,
  input  logic          res_pop,
  output logic [CW-1:0] credits,
`ifdef PE_SCHED_PERF_EN
  output logic [31:0]   perf_issue,
  output logic [31:0]   perf_stall,
`endif
  output logic          busy,
  output logic          err_mode
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_SWITCH = 2'd2
  } state_t;

  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_pe_mode;
  logic [CW-1:0] r_credits;
  logic          r_grp_open;
  logic          r_force_clr;
  logic          r_acc_clr;
  logic          r_err_mode;

  // Tag stage 0 is the issue cycle (drives pe_issue); stage PIPE_LAT is the
  // result cycle (drives res_*).
  logic          r_tag_v    [0:PIPE_LAT];
  logic          r_tag_last [0:PIPE_LAT];
  logic [1:0]    r_tag_mode [0:PIPE_LAT];

  logic          w_in_ready;
  logic          w_reserved;
  logic          w_accept;
  logic          w_issue_acc;
  logic          w_mode_chg;
  logic          w_pop_eff;
  logic          w_inflight;

  assign w_reserved  = (in_mode == 2'b11);
  assign w_accept    = in_valid & w_in_ready;
  assign w_issue_acc = w_accept & ~w_reserved;
  // A pop at full credits is ignored unless it pairs with an accept.
  assign w_pop_eff   = res_pop & ((r_credits != CRED_MAX) | w_issue_acc);
  assign w_mode_chg  = (r_state == S_SWITCH) & in_valid & (in_mode != r_pe_mode);

  // The result stage is excluded: a result being handed to the buffer
  // no longer blocks a mode switch.
  always_comb begin
    w_inflight = 1'b0;
    for (int k = 0; k < PIPE_LAT; k++) begin
      w_inflight = w_inflight | r_tag_v[k];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_RUN: begin
        w_in_ready = w_reserved | ((in_mode == r_pe_mode) & (r_credits != '0));
        if (in_valid && !w_reserved && (in_mode != r_pe_mode)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!w_inflight) begin
          w_state_nxt = S_SWITCH;
        end
      end
      S_SWITCH: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_pe_mode   <= 2'b00;
      r_credits   <= CRED_MAX;
      r_grp_open  <= 1'b0;
      r_force_clr <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_err_mode  <= 1'b0;
      for (int k = 0; k <= PIPE_LAT; k++) begin
        r_tag_v[k]    <= 1'b0;
        r_tag_last[k] <= 1'b0;
        r_tag_mode[k] <= 2'b00;
      end
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_grp_open <= ~in_last;
      end

      // SWITCH never accepts, so clearing and setting r_force_clr cannot
      // collide in the same cycle.
      if (w_issue_acc) begin
        r_force_clr <= 1'b0;
      end
      if (w_mode_chg) begin
        r_pe_mode   <= in_mode;
        r_force_clr <= 1'b1;
      end

      if ((w_accept && w_reserved) || (w_mode_chg && r_grp_open)) begin
        r_err_mode <= 1'b1;
      end

      r_acc_clr <= w_issue_acc & (~r_grp_open | r_force_clr);

      if (w_issue_acc && !w_pop_eff) begin
        r_credits <= r_credits - CRED_ONE;
      end else if (w_pop_eff && !w_issue_acc) begin
        r_credits <= r_credits + CRED_ONE;
      end

      r_tag_v[0]    <= w_issue_acc;
      r_tag_last[0] <= in_last;
      r_tag_mode[0] <= r_pe_mode;
      for (int k = 1; k <= PIPE_LAT; k++) begin
        r_tag_v[k]    <= r_tag_v[k-1];
        r_tag_last[k] <= r_tag_last[k-1];
        r_tag_mode[k] <= r_tag_mode[k-1];
      end
    end
  end

`ifdef PE_SCHED_PERF_EN
  logic [31:0] r_perf_issue;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_issue <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (r_tag_v[0] && (r_perf_issue != 32'hFFFF_FFFF)) begin
        r_perf_issue <= r_perf_issue + 32'd1;
      end
      if (in_valid && !w_in_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_issue = r_perf_issue;
  assign perf_stall = r_perf_stall;
`endif

  assign in_ready   = w_in_ready;
  assign pe_issue   = r_tag_v[0];
  assign pe_mode    = r_pe_mode;
  assign pe_acc_clr = r_acc_clr;
  assign res_valid  = r_tag_v[PIPE_LAT];
  assign res_last   = r_tag_last[PIPE_LAT];
  assign res_mode   = r_tag_mode[PIPE_LAT];
  assign credits    = r_credits;
  assign busy       = (r_state != S_RUN) | w_inflight;
  assign err_mode   = r_err_mode;

endmodule

// File: tb/tb_pe_mode_scheduler.sv
// tb/tb_pe_mode_scheduler.sv - scoreboard bench for pe_mode_scheduler

module tb_pe_mode_scheduler;

  localparam int PIPE_LAT = 4;
  localparam int CREDITS  = 8;
  localparam int CW       = $clog2(CREDITS + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic          in_last;
  logic          pe_issue;
  logic [1:0]    pe_mode;
  logic          pe_acc_clr;
  logic          res_valid;
  logic          res_last;
  logic [1:0]    res_mode;
  logic          res_pop;
  logic [CW-1:0] credits;
  logic          busy;
  logic          err_mode;
`ifdef PE_SCHED_PERF_EN
  logic [31:0]   perf_issue;
  logic [31:0]   perf_stall;
`endif

  pe_mode_scheduler #(.PIPE_LAT(PIPE_LAT), .CREDITS(CREDITS)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_last    (in_last),
    .pe_issue   (pe_issue),
    .pe_mode    (pe_mode),
    .pe_acc_clr (pe_acc_clr),
    .res_valid  (res_valid),
    .res_last   (res_last),
    .res_mode   (res_mode),
    .res_pop    (res_pop),
    .credits    (credits),
`ifdef PE_SCHED_PERF_EN
    .perf_issue (perf_issue),
    .perf_stall (perf_stall),
`endif
    .busy       (busy),
    .err_mode   (err_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       last;
    logic [1:0] mode;
    logic       clr;
    int         cyc;
  } exp_t;

  exp_t q_iss[$];
  exp_t q_res[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_res = 0;
  int   last_res_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at the negedge of a handshake cycle.
  task automatic push_exp(input logic [1:0] m, input logic l, input logic clr);
    q_iss.push_back('{last: l, mode: m, clr: clr, cyc: cyc + 1});
    q_res.push_back('{last: l, mode: m, clr: clr, cyc: cyc + 1 + PIPE_LAT});
  endtask

  always @(negedge clk) begin
    if (pe_issue) begin
      if (q_iss.size() == 0) begin
        check_eq("unexp_issue", 32'(pe_issue), 32'(0));
      end else begin
        mon_e = q_iss.pop_front();
        check_eq("issue_cyc", 32'(cyc), 32'(mon_e.cyc));
        check_eq("acc_clr", 32'(pe_acc_clr), 32'(mon_e.clr));
        check_eq("issue_mode", 32'(pe_mode), 32'(mon_e.mode));
      end
    end
    if (res_valid) begin
      n_res++;
      last_res_cyc = cyc;
      if (q_res.size() == 0) begin
        check_eq("unexp_res", 32'(res_valid), 32'(0));
      end else begin
        mon_e = q_res.pop_front();
        check_eq("res_cyc", 32'(cyc), 32'(mon_e.cyc));
        check_eq("res_last", 32'(res_last), 32'(mon_e.last));
        check_eq("res_mode", 32'(res_mode), 32'(mon_e.mode));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop1();
    res_pop = 1'b1;
    @(posedge clk);
    #1;
    res_pop = 1'b0;
  endtask

  task automatic send(input logic [1:0] m, input logic l, input logic clr, output int acc_cyc);
    int waited;
    waited  = 0;
    acc_cyc = -1;
    in_valid = 1'b1;
    in_mode  = m;
    in_last  = l;
    while (1) begin
      @(negedge clk);
      if (in_ready || waited == 40) break;
      waited++;
      @(posedge clk);
      #1;
    end
    if (in_ready) begin
      acc_cyc = cyc;
      if (m != 2'b11) push_exp(m, l, clr);
    end else begin
      check_eq("accept_timeout", 32'(in_ready), 32'(1));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check_eq({tag, "_issue"}, 32'(pe_issue), 32'(0));
    check_eq({tag, "_clr"}, 32'(pe_acc_clr), 32'(0));
    check_eq({tag, "_mode"}, 32'(pe_mode), 32'(0));
    check_eq({tag, "_resv"}, 32'(res_valid), 32'(0));
    check_eq({tag, "_resl"}, 32'(res_last), 32'(0));
    check_eq({tag, "_resm"}, 32'(res_mode), 32'(0));
    check_eq({tag, "_credits"}, 32'(credits), 32'(CREDITS));
    check_eq({tag, "_busy"}, 32'(busy), 32'(0));
    check_eq({tag, "_err"}, 32'(err_mode), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, a1, a3, afp;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_mode  = 2'b00;
    in_last  = 1'b0;
    res_pop  = 1'b0;
    idle(3);
    rst_n = 1'b1;

    // Reset state
    check_reset_vals("reset");
    @(negedge clk);
    check_eq("reset_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;

    // Streaming: 6 FP16 back-to-back, last on the 6th
    send(2'b00, 1'b0, 1'b1, a1);
    for (int i = 2; i <= 6; i++) send(2'b00, (i == 6), 1'b0, a);
    check_eq("stream_b2b", 32'(a - a1), 32'(5));
    idle(8);
    check_eq("stream_nres", 32'(n_res), 32'(6));
    check_eq("stream_credits", 32'(credits), 32'(2));

    // Credit exhaustion
    for (int i = 0; i < 6; i++) pop1();
    check_eq("refill_credits", 32'(credits), 32'(8));
    for (int i = 1; i <= 8; i++) send(2'b00, (i == 8), (i == 1), a);
    check_eq("exhaust_credits", 32'(credits), 32'(0));
    in_valid = 1'b1;
    in_mode  = 2'b00;
    in_last  = 1'b1;
    @(negedge clk);
    check_eq("ninth_blocked", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    res_pop = 1'b1;
    @(negedge clk);
    check_eq("ready_during_pop", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    res_pop = 1'b0;
    @(negedge clk);
    check_eq("ready_after_pop", 32'(in_ready), 32'(1));
    if (in_ready) push_exp(2'b00, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("one_accept_only", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_eq("credits_zero", 32'(credits), 32'(0));

    // Simultaneous accept and pop; pop at full
    for (int i = 0; i < 3; i++) pop1();
    check_eq("credits_three", 32'(credits), 32'(3));
    in_valid = 1'b1;
    in_mode  = 2'b00;
    in_last  = 1'b1;
    res_pop  = 1'b1;
    @(negedge clk);
    check_eq("simul_ready", 32'(in_ready), 32'(1));
    if (in_ready) push_exp(2'b00, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    res_pop  = 1'b0;
    check_eq("simul_credits", 32'(credits), 32'(3));
    for (int i = 0; i < 5; i++) pop1();
    check_eq("credits_full", 32'(credits), 32'(8));
    pop1();
    check_eq("pop_at_full", 32'(credits), 32'(8));
    idle(8);

    // Mode change after a closed FP16 group with 3 ops in flight
    send(2'b00, 1'b0, 1'b1, a);
    send(2'b00, 1'b0, 1'b0, a);
    send(2'b00, 1'b1, 1'b0, a3);
    send(2'b01, 1'b1, 1'b1, afp);
    check_eq("drain_last_res", 32'(last_res_cyc), 32'(a3 + 1 + PIPE_LAT));
    check_eq("switch_accept_cyc", 32'(afp), 32'(a3 + PIPE_LAT + 3));
    idle(8);
    check_eq("mode_fp32", 32'(pe_mode), 32'(1));
    check_eq("err_closed_grp", 32'(err_mode), 32'(0));
    check_eq("idle_busy", 32'(busy), 32'(0));

    // Mode change mid-group
    send(2'b01, 1'b0, 1'b1, a);
    send(2'b10, 1'b1, 1'b1, a);
    idle(8);
    check_eq("mode_fp64", 32'(pe_mode), 32'(2));
    check_eq("err_mid_grp", 32'(err_mode), 32'(1));

    // Reserved mode after a fresh reset
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check_reset_vals("rst2");
    send(2'b11, 1'b1, 1'b0, a);
    idle(3);
    check_eq("rsvd_credits", 32'(credits), 32'(8));
    check_eq("rsvd_err", 32'(err_mode), 32'(1));
    check_eq("rsvd_mode", 32'(pe_mode), 32'(0));

    // Reset with ops in flight
    send(2'b00, 1'b0, 1'b1, a);
    send(2'b00, 1'b0, 1'b0, a);
    send(2'b00, 1'b1, 1'b0, a);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    q_iss.delete();
    q_res.delete();
    a = n_res;
    check_reset_vals("rst3");
    idle(10);
    check_eq("no_res_after_rst", 32'(n_res), 32'(a));

    check_eq("sb_iss_empty", 32'(q_iss.size()), 32'(0));
    check_eq("sb_res_empty", 32'(q_res.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pe_mode_scheduler.md
# pe_mode_scheduler

Issue scheduler for the multi-precision FP processing element. It accepts a stream of product-group requests (FP16 ×10, FP32 ×5 or FP64 ×1 per request) and drives the registered precision mode into the exponent-compare / alignment / multiply pipeline. It serialises mode changes by draining the pipeline first. It tracks credits for the downstream result buffer and tags each result leaving the pipeline with its mode and end-of-group flag.

## Interface
Parameters:
- PIPE_LAT, 4, datapath latency in cycles from pe_issue to the result being valid; legal range ≥1.
- CREDITS, 8, number of result-buffer entries downstream; legal range ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_mode  in  2  00 = FP16, 01 = FP32, 10 = FP64, 11 = reserved.
- in_last  in  1  request is the last of an accumulation group.
- pe_issue  out  1  one-cycle strobe that loads the PE operand registers.
- pe_mode  out  2  registered mode driven to the whole PE datapath.
- pe_acc_clr  out  1  qualifies pe_issue; clear the accumulator and start a new group.
- res_valid  out  1  one-cycle strobe; PE result valid this cycle.
- res_last  out  1  end-of-group tag, qualified by res_valid.
- res_mode  out  2  mode tag, qualified by res_valid.
- res_pop  in  1  downstream buffer freed one entry; returns one credit.
- credits  out  $clog2(CREDITS+1)  free credits.
- busy  out  1  state != RUN, or any operation in flight.
- err_mode  out  1  sticky error flag; cleared only by reset.

## Operation
States:
- RUN:
  - in_ready = (in_mode == pe_mode) & (credits > 0), or in_mode == 11.
  - If in_valid, in_mode ∉ {pe_mode, 11}: in_ready = 0 and the next state is DRAIN.
- DRAIN:
  - in_ready = 0.
  - Stays in DRAIN until no pe_issue is pending and all pipeline valid stages are empty; then goes to SWITCH.
  - Results already in the external buffer do not block the drain.
- SWITCH:
  - Lasts exactly 1 cycle with in_ready = 0.
  - pe_mode <= in_mode, sampled in this cycle. If in_valid has dropped, pe_mode is unchanged.
  - Next state is RUN.

Group tracking:
- An internal flag grp_open is set by any accepted non-last request and cleared by an accepted in_last request.
- pe_acc_clr = 1 on an issue when grp_open was 0, or when the issue is the first one after a SWITCH that changed pe_mode.
- Changing mode while grp_open = 1 still proceeds, sets err_mode, and forces pe_acc_clr on the next issue.

Reserved mode:
- A request with in_mode = 11 is consumed without credit and without pe_issue, and sets err_mode.

Credits:
- Reset value is CREDITS.
- An accepted request (non-reserved) decrements credits; res_pop increments them.
- Accept and pop in the same cycle: credits unchanged.
- res_pop while credits == CREDITS is ignored and does not wrap.
- credits never underflows, because in_ready is gated by credits > 0.

Tag pipeline:
- A PIPE_LAT-stage shift register of {valid, last, mode} entries advances every cycle.
- It has no stall: credits guarantee the buffer can accept every result.

## Timing
- Handshake in cycle T: pe_issue, pe_acc_clr and the tag enter stage 0 at T+1. res_valid, res_last and res_mode appear at T+1+PIPE_LAT.
- Back-to-back acceptance gives 1 issue per cycle.
- Mode-change penalty: the DRAIN cycles plus 1 SWITCH cycle. From an empty pipeline, DRAIN lasts 1 cycle.
- Reset values:
  - state = RUN, pe_mode = 00, credits = CREDITS.
  - pe_issue, pe_acc_clr, res_valid, res_last and busy = 0; res_mode = 00.
  - err_mode = 0, grp_open = 0.
  - All pipeline tag stages are cleared.
- Reset asserted mid-operation discards all in-flight tags; no res_valid is produced for them.

## Configuration
- PE_SCHED_PERF_EN defined adds two outputs:
  - perf_issue[31:0]: count of pe_issue cycles.
  - perf_stall[31:0]: count of cycles with in_valid & !in_ready.
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters are absent, and all other behaviour is identical.

## Test plan
- Streaming: PIPE_LAT = 4, 6 FP16 requests on consecutive cycles, the 6th with in_last, res_pop never asserted.
  - pe_issue on cycles 1–6, with pe_acc_clr on the first issue only.
  - res_valid on cycles 5–10; res_last only on cycle 10.
  - credits = 2.
- Credit exhaustion: 8 requests with no pops.
  - in_ready = 0 on the 9th request.
  - One res_pop → exactly 1 further accept, the next cycle.
- Simultaneous accept and res_pop with credits = 3 → credits stays 3. res_pop while credits = 8 → stays 8.
- Mode change: an FP32 request arrives while 3 FP16 ops are in flight.
  - DRAIN until the last FP16 res_valid, then one SWITCH cycle, then pe_mode = 01.
  - The FP32 issue has pe_acc_clr = 1, and err_mode = 0 (the group was closed).
- Error cases:
  - Mode change mid-group → err_mode = 1.
  - in_mode = 11 → consumed with no pe_issue, credits unchanged, err_mode = 1.
  - rst_n low for 1 cycle with ops in flight → no res_valid afterwards and all outputs at reset values.
